// File: rtl/common_types_pkg.sv
// Shared CSR addresses, access opcodes and bit positions for the machine-mode
// CSR file and its trap logic.
package common_types_pkg;

  typedef enum logic [11:0] {
    CSR_MSTATUS   = 12'h300,
    CSR_MISA      = 12'h301,
    CSR_MIE       = 12'h304,
    CSR_MTVEC     = 12'h305,
    CSR_MSCRATCH  = 12'h340,
    CSR_MEPC      = 12'h341,
    CSR_MCAUSE    = 12'h342,
    CSR_MTVAL     = 12'h343,
    CSR_MIP       = 12'h344,
    CSR_MCYCLE    = 12'hB00,
    CSR_MINSTRET  = 12'hB02,
    CSR_MCYCLEH   = 12'hB80,
    CSR_MINSTRETH = 12'hB82,
    CSR_MHARTID   = 12'hF14
  } csr_addr_t;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_t;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MSTATUS_MPP_LO = 11;

  localparam int MI_MEI = 11;
  localparam int MI_MTI = 7;

  // MXL = 1 (32-bit), extension bit I.
  localparam logic [31:0] MISA_RV32I = 32'h4000_0100;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter whose halves can be overwritten by CSR writes;
// a write suppresses the increment for that cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [63:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (wr_lo || wr_hi) begin
      if (wr_lo) value_d[31:0]  = wdata;
      if (wr_hi) value_d[63:32] = wdata;
    end else if (inc) begin
      value_d = value_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/trap_csr_unit.sv
// Machine-mode CSR file: Zicsr read/modify/write, trap entry, mret and the
// interrupt-enable / trap-vector feedback to the exception unit.
module trap_csr_unit
  import common_types_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MHARTID     = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_en,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        csr_rs1_zero,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        exception,
  input  logic        interrupt,
  input  logic [31:0] exception_pc,
  input  logic [31:0] exception_cause,
  input  logic        mret,
  input  logic        ext_irq,
  input  logic        timer_irq,
  input  logic        instret_inc,
  output logic        interrupt_en,
  output logic [31:0] trap_vector,
  output logic [31:0] mepc_out
);

  logic        mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic        meie_q, meie_d, mtie_q, mtie_d;
  logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [63:0] mcycle, minstret;

  logic [31:0] mstatus_rd, mie_rd, mip_rd, old_val, wval;
  logic        addr_ok, addr_ro, access, wr_intent, csr_wr;

  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MIE]  = mst_mie_q;
    mstatus_rd[MSTATUS_MPIE] = mst_mpie_q;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mie_rd = '0;
    mie_rd[MI_MEI] = meie_q;
    mie_rd[MI_MTI] = mtie_q;
    mip_rd = '0;
    mip_rd[MI_MEI] = ext_irq;
    mip_rd[MI_MTI] = timer_irq;
  end

  always_comb begin
    old_val = '0;
    addr_ok = 1'b1;
    addr_ro = 1'b0;
    case (csr_addr)
      CSR_MSTATUS:   old_val = mstatus_rd;
      CSR_MISA:      begin old_val = MISA_RV32I; addr_ro = 1'b1; end
      CSR_MIE:       old_val = mie_rd;
      CSR_MTVEC:     old_val = mtvec_q;
      CSR_MSCRATCH:  old_val = mscratch_q;
      CSR_MEPC:      old_val = mepc_q;
      CSR_MCAUSE:    old_val = mcause_q;
      CSR_MTVAL:     old_val = mtval_q;
      CSR_MIP:       begin old_val = mip_rd; addr_ro = 1'b1; end
      CSR_MCYCLE:    old_val = mcycle[31:0];
      CSR_MCYCLEH:   old_val = mcycle[63:32];
      CSR_MINSTRET:  old_val = minstret[31:0];
      CSR_MINSTRETH: old_val = minstret[63:32];
      CSR_MHARTID:   begin old_val = MHARTID; addr_ro = 1'b1; end
      default:       addr_ok = 1'b0;
    endcase
  end

  // RS/RC with a zero source are pure reads, so they stay legal on read-only CSRs.
  assign access      = csr_en && (csr_op != CSR_NONE);
  assign wr_intent   = (csr_op == CSR_RW) || !csr_rs1_zero;
  assign csr_illegal = access && (!addr_ok || (addr_ro && wr_intent));
  assign csr_rdata   = (access && !csr_illegal) ? old_val : '0;
  assign csr_wr      = access && wr_intent && !csr_illegal && !exception;

  always_comb begin
    case (csr_op)
      CSR_RS:  wval = old_val | csr_wdata;
      CSR_RC:  wval = old_val & ~csr_wdata;
      default: wval = csr_wdata;
    endcase
  end

  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    meie_d     = meie_q;
    mtie_d     = mtie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (exception) begin
      mepc_d     = {exception_pc[31:2], 2'b00};
      mcause_d   = {interrupt, exception_cause[30:0]};
      mtval_d    = '0;
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
    end else begin
      if (csr_wr) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            mst_mie_d  = wval[MSTATUS_MIE];
            mst_mpie_d = wval[MSTATUS_MPIE];
          end
          CSR_MIE: begin
            meie_d = wval[MI_MEI];
            mtie_d = wval[MI_MTI];
          end
          CSR_MTVEC:    mtvec_d    = {wval[31:2], 1'b0, wval[0]};
          CSR_MSCRATCH: mscratch_d = wval;
          CSR_MEPC:     mepc_d     = {wval[31:2], 2'b00};
          CSR_MCAUSE:   mcause_d   = wval;
          CSR_MTVAL:    mtval_d    = wval;
          default: ;
        endcase
      end
      // mret outranks a same-cycle mstatus write.
      if (mret) begin
        mst_mie_d  = mst_mpie_q;
        mst_mpie_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      meie_q     <= 1'b0;
      mtie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      meie_q     <= meie_d;
      mtie_q     <= mtie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (csr_wr && (csr_addr == CSR_MCYCLE)),
    .wr_hi (csr_wr && (csr_addr == CSR_MCYCLEH)),
    .wdata (wval),
    .value (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (instret_inc),
    .wr_lo (csr_wr && (csr_addr == CSR_MINSTRET)),
    .wr_hi (csr_wr && (csr_addr == CSR_MINSTRETH)),
    .wdata (wval),
    .value (minstret)
  );

  logic unused_cause_msb;
  assign unused_cause_msb = exception_cause[31];

  assign interrupt_en = mst_mie_q && |(mie_rd & mip_rd);
  assign trap_vector  = (mtvec_q[0] && interrupt)
                      ? {mtvec_q[31:2], 2'b00} + {exception_cause[29:0], 2'b00}
                      : {mtvec_q[31:2], 2'b00};
  assign mepc_out     = mepc_q;

endmodule

// File: tb/tb_trap_csr_unit.sv
// Directed bench for trap_csr_unit: hand-written trap/mret/counter sequences
// followed by a table of CSR access vectors checked against read-back values.
module tb_trap_csr_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_rs1_zero;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        exception, interrupt;
  logic [31:0] exception_pc, exception_cause;
  logic        mret, ext_irq, timer_irq, instret_inc;
  logic        interrupt_en;
  logic [31:0] trap_vector, mepc_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  trap_csr_unit #(.MTVEC_RESET(32'h8000_0100), .MHARTID(32'd0)) dut (
    .clk(clk), .rst(rst),
    .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rs1_zero(csr_rs1_zero), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .exception(exception), .interrupt(interrupt), .exception_pc(exception_pc),
    .exception_cause(exception_cause), .mret(mret), .ext_irq(ext_irq),
    .timer_irq(timer_irq), .instret_inc(instret_inc), .interrupt_en(interrupt_en),
    .trap_vector(trap_vector), .mepc_out(mepc_out)
  );

  typedef struct {
    logic        en;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        rs1z;
    logic [31:0] exp_rdata;
    logic        exp_ill;
  } vec_t;

  localparam logic [1:0] RW = 2'b01, RS = 2'b10, RC = 2'b11;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_drive(input logic [1:0] op, input logic [11:0] a,
                           input logic [31:0] wd, input logic rz);
    csr_en = 1'b1; csr_op = op; csr_addr = a; csr_wdata = wd; csr_rs1_zero = rz;
  endtask

  task automatic csr_idle();
    csr_en = 1'b0; csr_op = 2'b00; csr_addr = '0; csr_wdata = '0; csr_rs1_zero = 1'b0;
  endtask

  // Pure read: combinational, consumes no clock edge.
  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string nm);
    csr_drive(RS, a, 32'h0, 1'b1);
    #1;
    chk(nm, csr_rdata, exp);
    csr_idle();
  endtask

  vec_t tbl [25];

  initial begin
    rst = 1'b1; csr_idle();
    exception = 0; interrupt = 0; exception_pc = 0; exception_cause = 0;
    mret = 0; ext_irq = 0; timer_irq = 0; instret_inc = 0;

    tbl[0]  = '{1, RW, 12'h340, 32'hDEAD_BEEF, 0, 32'h0000_0000, 0};
    tbl[1]  = '{1, RS, 12'h340, 32'h0000_0010, 0, 32'hDEAD_BEEF, 0};
    tbl[2]  = '{1, RC, 12'h340, 32'hF000_0000, 0, 32'hDEAD_BEFF, 0};
    tbl[3]  = '{1, RS, 12'h340, 32'h0000_0000, 1, 32'h0EAD_BEFF, 0};
    tbl[4]  = '{1, RW, 12'h341, 32'h0000_1237, 0, 32'h0000_0000, 0};
    tbl[5]  = '{1, RS, 12'h341, 32'h0000_0000, 1, 32'h0000_1234, 0};
    tbl[6]  = '{1, RW, 12'h305, 32'h0000_1003, 0, 32'h8000_0100, 0};
    tbl[7]  = '{1, RS, 12'h305, 32'h0000_0000, 1, 32'h0000_1001, 0};
    tbl[8]  = '{1, RW, 12'h301, 32'h0000_0005, 0, 32'h0000_0000, 1};
    tbl[9]  = '{1, RS, 12'h301, 32'h0000_0000, 1, 32'h4000_0100, 0};
    tbl[10] = '{1, RC, 12'hF14, 32'h0000_0000, 1, 32'h0000_0000, 0};
    tbl[11] = '{1, RW, 12'hF14, 32'h0000_0001, 0, 32'h0000_0000, 1};
    tbl[12] = '{1, RS, 12'h7C0, 32'h0000_0000, 1, 32'h0000_0000, 1};
    tbl[13] = '{1, RW, 12'h304, 32'hFFFF_FFFF, 0, 32'h0000_0000, 0};
    tbl[14] = '{1, RS, 12'h304, 32'h0000_0000, 1, 32'h0000_0880, 0};
    tbl[15] = '{1, RW, 12'h342, 32'h8000_000B, 0, 32'h0000_0000, 0};
    tbl[16] = '{1, RC, 12'h342, 32'h0000_0000, 1, 32'h8000_000B, 0};
    tbl[17] = '{1, RW, 12'h343, 32'h0000_0055, 0, 32'h0000_0000, 0};
    tbl[18] = '{1, RW, 12'h300, 32'hFFFF_FFFF, 0, 32'h0000_1800, 0};
    tbl[19] = '{1, RC, 12'h300, 32'h0000_0088, 0, 32'h0000_1888, 0};
    tbl[20] = '{1, RS, 12'h300, 32'h0000_0000, 1, 32'h0000_1800, 0};
    tbl[21] = '{0, RW, 12'h340, 32'h0000_0001, 0, 32'h0000_0000, 0};
    tbl[22] = '{1, RS, 12'h340, 32'h0000_0000, 1, 32'h0EAD_BEFF, 0};
    tbl[23] = '{1, RS, 12'h344, 32'h0000_0000, 1, 32'h0000_0000, 0};
    tbl[24] = '{1, RS, 12'h344, 32'h0000_0001, 0, 32'h0000_0000, 1};

    tick(); tick();
    rst = 1'b0;

    // Reset state.
    chk("rst_trap_vector", trap_vector, 32'h8000_0100);
    chk("rst_interrupt_en", {31'b0, interrupt_en}, 32'h0);
    chk("rst_mepc_out", mepc_out, 32'h0);
    chk("rst_csr_illegal", {31'b0, csr_illegal}, 32'h0);
    chk("rst_csr_rdata", csr_rdata, 32'h0);
    rd(12'h300, 32'h0000_1800, "rst_mstatus");

    // Enable MIE, then MEIE with ext_irq pending.
    csr_drive(RS, 12'h300, 32'h8, 1'b0);
    tick();
    ext_irq = 1'b1;
    csr_drive(RW, 12'h304, 32'h800, 1'b0);
    #1;
    chk("irq_en_before_mie", {31'b0, interrupt_en}, 32'h0);
    tick();
    csr_idle();
    chk("irq_en_after_mie", {31'b0, interrupt_en}, 32'h1);

    // Trap entry with a colliding CSR write that must be dropped.
    exception = 1; interrupt = 0; exception_pc = 32'h47; exception_cause = 32'h2;
    csr_drive(RW, 12'h340, 32'h5, 1'b0);
    tick();
    exception = 0; csr_idle();
    chk("trap_mepc", mepc_out, 32'h44);
    chk("trap_irq_en", {31'b0, interrupt_en}, 32'h0);
    rd(12'h342, 32'h2, "trap_mcause");
    rd(12'h300, 32'h0000_1880, "trap_mstatus");
    rd(12'h340, 32'h0, "trap_mscratch_kept");
    tick();
    rd(12'h343, 32'h0, "trap_mtval");

    // Vectored mtvec.
    csr_drive(RW, 12'h305, 32'h0000_1001, 1'b0);
    tick();
    csr_idle();
    interrupt = 1; exception_cause = 32'h7;
    #1 chk("tvec_vectored_irq", trap_vector, 32'h0000_101C);
    interrupt = 0;
    #1 chk("tvec_vectored_exc", trap_vector, 32'h0000_1000);
    exception_cause = 0;

    // mret.
    tick();
    mret = 1;
    tick();
    mret = 0;
    rd(12'h300, 32'h0000_1888, "mret_mstatus");
    chk("mret_mepc", mepc_out, 32'h44);
    chk("mret_irq_en", {31'b0, interrupt_en}, 32'h1);

    // mret coinciding with exception is ignored.
    tick();
    exception = 1; mret = 1; exception_pc = 32'h100; exception_cause = 32'h3;
    tick();
    exception = 0; mret = 0; exception_cause = 0; ext_irq = 0;
    rd(12'h300, 32'h0000_1880, "exc_mret_mstatus");
    chk("exc_mret_mepc", mepc_out, 32'h100);
    rd(12'h342, 32'h3, "exc_mret_mcause");

    // mcycle low-half carry into high half.
    tick();
    csr_drive(RW, 12'hB00, 32'hFFFF_FFFF, 1'b0);
    tick();
    csr_drive(RW, 12'hB80, 32'h0, 1'b0);
    tick();
    csr_idle();
    tick();
    rd(12'hB80, 32'h1, "mcycleh_carry");
    rd(12'hB00, 32'h0, "mcycle_carry");

    // 64-bit wrap.
    csr_drive(RW, 12'hB00, 32'hFFFF_FFFF, 1'b0);
    tick();
    csr_drive(RW, 12'hB80, 32'hFFFF_FFFF, 1'b0);
    tick();
    csr_idle();
    tick();
    rd(12'hB80, 32'h0, "mcycleh_wrap");
    rd(12'hB00, 32'h0, "mcycle_wrap");

    // minstret: write suppresses the same-cycle increment.
    instret_inc = 1;
    csr_drive(RW, 12'hB02, 32'h5, 1'b0);
    tick();
    csr_idle();
    tick(); tick(); tick();
    instret_inc = 0;
    rd(12'hB02, 32'h8, "minstret_count");
    rd(12'hB82, 32'h0, "minstreth_count");

    // misa: write is illegal, zero-source RS is a legal read.
    csr_drive(RW, 12'h301, 32'h0, 1'b0);
    #1;
    chk("misa_wr_illegal", {31'b0, csr_illegal}, 32'h1);
    chk("misa_wr_rdata", csr_rdata, 32'h0);
    csr_drive(RS, 12'h301, 32'h0, 1'b1);
    #1;
    chk("misa_rd_legal", {31'b0, csr_illegal}, 32'h0);
    chk("misa_rd_rdata", csr_rdata, 32'h4000_0100);
    csr_idle();

    // Reset mid-count clears counters and CSRs.
    tick();
    rst = 1;
    tick();
    rst = 0;
    rd(12'hB00, 32'h0, "rst_mcycle");
    rd(12'hB02, 32'h0, "rst_minstret");
    chk("rst2_mepc", mepc_out, 32'h0);

    for (int i = 0; i < 25; i++) begin
      csr_en = tbl[i].en; csr_op = tbl[i].op; csr_addr = tbl[i].addr;
      csr_wdata = tbl[i].wdata; csr_rs1_zero = tbl[i].rs1z;
      #1;
      chk($sformatf("vec%0d_rdata", i), csr_rdata, tbl[i].exp_rdata);
      chk($sformatf("vec%0d_illegal", i), {31'b0, csr_illegal}, {31'b0, tbl[i].exp_ill});
      tick();
    end
    csr_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
